// File: rtl/fir_coef_loader.sv
// fir_coef_loader: sequences one coefficient load into the FIR_Filters
// coefficient RAMs. It resets the FIR write address, confirms that the address
// reached zero, then turns the host byte stream (MSB then LSB) into 16-bit
// write strobes. Select and data are held long enough for the FIR's registered
// enable and its late RAM write. Audio processing is gated off while a load runs.
module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,
  parameter int MAX_COEFS   = 511
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [5:0] cmd_filter,
  input  logic [8:0] cmd_count,
  input  logic       cmd_abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       audio_en_in,
  output logic       audio_en_out,
  input  logic       wr_addr_zero,
  output logic       coef_addr_rst,
  output logic [5:0] coef_select,
  output logic [7:0] coef_wr_msb_data,
  output logic [7:0] coef_wr_lsb_data,
  output logic       coefficient_wr_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  // FSM encoding
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR_RST = 3'd1;
  localparam logic [2:0] S_ADDR_CHK = 3'd2;
  localparam logic [2:0] S_GET_MSB  = 3'd3;
  localparam logic [2:0] S_GET_LSB  = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;
  localparam logic [2:0] S_SETTLE   = 3'd6;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_ADDR_NZ = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  // Limits widened by one bit so the comparisons cannot wrap
  localparam logic [6:0] NUM_FILTERS_W = 7'(NUM_FILTERS);
  localparam logic [9:0] MAX_COEFS_W   = 10'(MAX_COEFS);

  logic [2:0] state_q,     state_d;
  logic [8:0] remaining_q, remaining_d;
  logic       settle_q,    settle_d;
  logic [5:0] sel_q,       sel_d;
  logic [7:0] msb_q,       msb_d;
  logic [7:0] lsb_q,       lsb_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;
  logic [1:0] err_code_q,  err_code_d;

  logic       cmd_bad;

  // A command is rejected for an out-of-range filter or an empty/oversized count
  assign cmd_bad = ({1'b0, cmd_filter} >= NUM_FILTERS_W) ||
                   (cmd_count == 9'd0) ||
                   ({1'b0, cmd_count} > MAX_COEFS_W);

  // Next-state and datapath update; abort overrides everything outside IDLE
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    sel_d       = sel_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if ((state_q != S_IDLE) && cmd_abort) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_ABORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_bad) begin
              err_d      = 1'b1;
              err_code_d = ERR_BAD_CMD;
            end else begin
              sel_d       = cmd_filter;
              remaining_d = cmd_count;
              err_code_d  = ERR_NONE;
              state_d     = S_ADDR_RST;
            end
          end
        end
        S_ADDR_RST: state_d = S_ADDR_CHK;
        S_ADDR_CHK: begin
          if (!wr_addr_zero) begin
            err_d      = 1'b1;
            err_code_d = ERR_ADDR_NZ;
            state_d    = S_IDLE;
          end else begin
            state_d = S_GET_MSB;
          end
        end
        S_GET_MSB: begin
          if (byte_valid) begin
            msb_d   = byte_data;
            state_d = S_GET_LSB;
          end
        end
        S_GET_LSB: begin
          if (byte_valid) begin
            lsb_d   = byte_data;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          remaining_d = remaining_q - 9'd1;
          settle_d    = 1'b0;
          state_d     = S_SETTLE;
        end
        S_SETTLE: begin
          // Two cycles: the FIR registers the enable, then writes the RAM
          if (!settle_q) begin
            settle_d = 1'b1;
          end else if (remaining_q == 9'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GET_MSB;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; reset also suppresses any abort error
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 9'd0;
      settle_q    <= 1'b0;
      sel_q       <= 6'd0;
      msb_q       <= 8'd0;
      lsb_q       <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      sel_q       <= sel_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Strobes and handshakes decode straight from the state register
  assign busy              = (state_q != S_IDLE);
  assign coef_addr_rst     = (state_q == S_ADDR_RST);
  assign byte_ready        = (state_q == S_GET_MSB) || (state_q == S_GET_LSB);
  assign coefficient_wr_en = (state_q == S_WRITE);
  assign audio_en_out      = audio_en_in && !busy;

  assign coef_select       = sel_q;
  assign coef_wr_msb_data  = msb_q;
  assign coef_wr_lsb_data  = lsb_q;
  assign done              = done_q;
  assign err               = err_q;
  assign err_code          = err_code_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed testbench for fir_coef_loader. Each scenario task drives a load and
// compares what it observed against hand-derived cycle positions and values.
// Cycle k = 1 is the cycle right after the edge that samples cmd_start.
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_start, cmd_abort, byte_valid, audio_en_in, wr_addr_zero;
  logic [5:0] cmd_filter;
  logic [8:0] cmd_count;
  logic [7:0] byte_data;
  logic       byte_ready, audio_en_out, coef_addr_rst, coefficient_wr_en;
  logic       busy, done, err;
  logic [5:0] coef_select;
  logic [7:0] coef_wr_msb_data, coef_wr_lsb_data;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation records filled by run_load
  logic [7:0]  tb_bytes [16];
  int          wr_k [$];
  logic [15:0] wr_val [$];
  logic [5:0]  wr_sel [$];
  int          rst_cnt, rst_k, done_k, done_cnt, err_cnt, err_k;
  int          first_ready_k, audio_bad, busy_cnt, window_bad;
  logic [1:0]  err_code_seen;

  fir_coef_loader dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_filter(cmd_filter),
    .cmd_count(cmd_count), .cmd_abort(cmd_abort), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .audio_en_in(audio_en_in),
    .audio_en_out(audio_en_out), .wr_addr_zero(wr_addr_zero),
    .coef_addr_rst(coef_addr_rst), .coef_select(coef_select),
    .coef_wr_msb_data(coef_wr_msb_data), .coef_wr_lsb_data(coef_wr_lsb_data),
    .coefficient_wr_en(coefficient_wr_en), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Issue one cmd_start and observe `cycles` cycles. Bytes come from tb_bytes
  // with byte_valid high, except for a 10-cycle gap once `stall_idx` bytes have
  // been accepted. cmd_abort is pulsed during cycle abort_k (0 = never).
  task automatic run_load(input logic [5:0] f, input logic [8:0] n, input int cycles,
                          input int stall_idx, input int abort_k);
    int idx = 0;
    int stall_left = 0;
    int win = 0;
    logic hs;
    logic [15:0] cur_val = 16'h0;
    logic [5:0]  cur_sel = 6'h0;
    wr_k.delete(); wr_val.delete(); wr_sel.delete();
    rst_cnt = 0; rst_k = 0; done_k = 0; done_cnt = 0; err_cnt = 0; err_k = 0;
    first_ready_k = 0; audio_bad = 0; busy_cnt = 0; window_bad = 0; err_code_seen = 2'd0;
    @(negedge clk);
    cmd_filter = f; cmd_count = n; cmd_start = 1'b1; byte_valid = 1'b1; byte_data = tb_bytes[0];
    @(posedge clk);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      cmd_start = 1'b0; cmd_abort = 1'b0;
      if (stall_left > 0) begin byte_valid = 1'b0; stall_left--; end
      else byte_valid = 1'b1;
      byte_data = (idx < 16) ? tb_bytes[idx] : 8'h00;
      #1;
      if (win > 0) begin
        if ({coef_wr_msb_data, coef_wr_lsb_data} !== cur_val || coef_select !== cur_sel) window_bad++;
        win--;
      end
      if (coefficient_wr_en) begin
        cur_val = {coef_wr_msb_data, coef_wr_lsb_data}; cur_sel = coef_select; win = 2;
        wr_k.push_back(k); wr_val.push_back(cur_val); wr_sel.push_back(cur_sel);
      end
      if (coef_addr_rst) begin rst_cnt++; if (rst_k == 0) rst_k = k; end
      if (done) begin done_cnt++; if (done_k == 0) done_k = k; end
      if (err) begin err_cnt++; if (err_k == 0) begin err_k = k; err_code_seen = err_code; end end
      if (byte_ready && first_ready_k == 0) first_ready_k = k;
      if (busy) busy_cnt++;
      if (audio_en_out !== (audio_en_in && !busy)) audio_bad++;
      hs = byte_valid && byte_ready;
      if (k == abort_k) cmd_abort = 1'b1;
      @(posedge clk);
      if (hs) begin idx++; if (idx == stall_idx) stall_left = 10; end
    end
    @(negedge clk);
    cmd_abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    cmd_filter = 6'd0; cmd_count = 9'd0; audio_en_in = 1'b1; wr_addr_zero = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    n_cmp++; if (coef_addr_rst !== 1'b0) begin n_bad++; $display("FAIL reset_addr_rst: got %b want 0", coef_addr_rst); end
    n_cmp++; if (coefficient_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", coefficient_wr_en); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
    n_cmp++; if (coef_select !== 6'd0) begin n_bad++; $display("FAIL reset_select: got %0d want 0", coef_select); end
    n_cmp++; if ({coef_wr_msb_data, coef_wr_lsb_data} !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", {coef_wr_msb_data, coef_wr_lsb_data}); end
    n_cmp++; if (audio_en_out !== 1'b1) begin n_bad++; $display("FAIL reset_audio: got %b want 1", audio_en_out); end
  endtask

  task automatic test_valid_load();
    logic [15:0] exp_val [3];
    exp_val[0] = 16'h1234; exp_val[1] = 16'h5678; exp_val[2] = 16'h9ABC;
    tb_bytes[0] = 8'h12; tb_bytes[1] = 8'h34; tb_bytes[2] = 8'h56;
    tb_bytes[3] = 8'h78; tb_bytes[4] = 8'h9A; tb_bytes[5] = 8'hBC;
    run_load(6'd2, 9'd3, 25, -1, 0);
    n_cmp++; if (rst_cnt != 1 || rst_k != 1) begin n_bad++; $display("FAIL load_addr_rst: got count %0d at k=%0d want 1 at k=1", rst_cnt, rst_k); end
    n_cmp++; if (first_ready_k != 3) begin n_bad++; $display("FAIL load_first_ready: got k=%0d want k=3", first_ready_k); end
    n_cmp++; if (wr_k.size() != 3) begin n_bad++; $display("FAIL load_strobe_count: got %0d want 3", wr_k.size()); end
    for (int i = 0; i < 3 && i < wr_k.size(); i++) begin
      n_cmp++; if (wr_k[i] != 5 + 5 * i) begin n_bad++; $display("FAIL load_strobe_cycle[%0d]: got k=%0d want k=%0d", i, wr_k[i], 5 + 5 * i); end
      n_cmp++; if (wr_val[i] !== exp_val[i]) begin n_bad++; $display("FAIL load_strobe_data[%0d]: got %h want %h", i, wr_val[i], exp_val[i]); end
      n_cmp++; if (wr_sel[i] !== 6'd2) begin n_bad++; $display("FAIL load_strobe_sel[%0d]: got %0d want 2", i, wr_sel[i]); end
    end
    n_cmp++; if (done_cnt != 1 || done_k - 1 != 17) begin n_bad++; $display("FAIL load_done: got %0d pulses, %0d cycles after start; want 1, 17", done_cnt, done_k - 1); end
    n_cmp++; if (busy_cnt != 17) begin n_bad++; $display("FAIL load_busy_cycles: got %0d want 17", busy_cnt); end
    n_cmp++; if (audio_bad != 0) begin n_bad++; $display("FAIL load_audio_gate: got %0d bad cycles want 0", audio_bad); end
    n_cmp++; if (window_bad != 0) begin n_bad++; $display("FAIL load_write_window: got %0d unstable cycles want 0", window_bad); end
    n_cmp++; if (err_cnt != 0) begin n_bad++; $display("FAIL load_no_err: got %0d err cycles want 0", err_cnt); end
    n_cmp++; if (coef_select !== 6'd2 || {coef_wr_msb_data, coef_wr_lsb_data} !== 16'h9ABC) begin n_bad++; $display("FAIL load_retain: got sel %0d data %h want 2 9abc", coef_select, {coef_wr_msb_data, coef_wr_lsb_data}); end
  endtask

  // cmd_count is 9 bits wide, so a count of 512 arrives as 0 and is covered by the zero-count vector.
  task automatic test_bad_cmd();
    logic [5:0] bad_f [3];
    logic [8:0] bad_n [3];
    bad_f[0] = 6'd4;  bad_n[0] = 9'd3;
    bad_f[1] = 6'd1;  bad_n[1] = 9'd0;
    bad_f[2] = 6'd63; bad_n[2] = 9'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cmd_filter = bad_f[i]; cmd_count = bad_n[i]; cmd_start = 1'b1; byte_valid = 1'b1;
      @(negedge clk); cmd_start = 1'b0;
      n_cmp++; if (err !== 1'b1 || err_code !== 2'd1) begin n_bad++; $display("FAIL bad_cmd_err[%0d]: got %b/%0d want 1/1", i, err, err_code); end
      n_cmp++; if (busy !== 1'b0 || coefficient_wr_en !== 1'b0 || byte_ready !== 1'b0) begin n_bad++; $display("FAIL bad_cmd_idle[%0d]: got busy %b wr %b rdy %b want 0 0 0", i, busy, coefficient_wr_en, byte_ready); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b0 || err_code !== 2'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL bad_cmd_after[%0d]: got err %b code %0d busy %b want 0 1 0", i, err, err_code, busy); end
      n_cmp++; if (coef_select !== 6'd2) begin n_bad++; $display("FAIL bad_cmd_select[%0d]: got %0d want 2", i, coef_select); end
    end
    @(negedge clk); cmd_abort = 1'b1;
    @(negedge clk); cmd_abort = 1'b0;
    n_cmp++; if (err !== 1'b0 || err_code !== 2'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_abort: got err %b code %0d busy %b want 0 1 0", err, err_code, busy); end
  endtask

  task automatic test_addr_not_zero();
    wr_addr_zero = 1'b0;
    run_load(6'd1, 9'd2, 12, -1, 0);
    wr_addr_zero = 1'b1;
    n_cmp++; if (err_cnt != 1 || err_k != 3 || err_code_seen !== 2'd2) begin n_bad++; $display("FAIL addr_err: got %0d pulses at k=%0d code %0d want 1 at k=3 code 2", err_cnt, err_k, err_code_seen); end
    n_cmp++; if (wr_k.size() != 0 || first_ready_k != 0 || done_cnt != 0) begin n_bad++; $display("FAIL addr_no_write: got strobes %0d ready k=%0d done %0d want 0 0 0", wr_k.size(), first_ready_k, done_cnt); end
    n_cmp++; if (busy_cnt != 2) begin n_bad++; $display("FAIL addr_busy_cycles: got %0d want 2", busy_cnt); end
    n_cmp++; if (err_code !== 2'd2) begin n_bad++; $display("FAIL addr_code_held: got %0d want 2", err_code); end
  endtask

  task automatic test_byte_stall();
    tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22; tb_bytes[2] = 8'h33; tb_bytes[3] = 8'h44;
    run_load(6'd0, 9'd2, 30, 3, 0);
    n_cmp++; if (wr_k.size() != 2) begin n_bad++; $display("FAIL stall_strobe_count: got %0d want 2", wr_k.size()); end
    if (wr_k.size() == 2) begin
      n_cmp++; if (wr_k[0] != 5 || wr_val[0] !== 16'h1122) begin n_bad++; $display("FAIL stall_first: got k=%0d %h want k=5 1122", wr_k[0], wr_val[0]); end
      n_cmp++; if (wr_k[1] != 20 || wr_val[1] !== 16'h3344) begin n_bad++; $display("FAIL stall_second: got k=%0d %h want k=20 3344", wr_k[1], wr_val[1]); end
    end
    n_cmp++; if (done_cnt != 1 || done_k != 23) begin n_bad++; $display("FAIL stall_done: got %0d at k=%0d want 1 at k=23", done_cnt, done_k); end
    n_cmp++; if (window_bad != 0 || audio_bad != 0) begin n_bad++; $display("FAIL stall_hold: got window %0d audio %0d want 0 0", window_bad, audio_bad); end
  endtask

  task automatic test_abort();
    tb_bytes[0] = 8'hDE; tb_bytes[1] = 8'hAD; tb_bytes[2] = 8'hBE; tb_bytes[3] = 8'hEF;
    run_load(6'd3, 9'd4, 25, -1, 6);
    n_cmp++; if (wr_k.size() != 1) begin n_bad++; $display("FAIL abort_strobes: got %0d want 1", wr_k.size()); end
    n_cmp++; if (err_cnt != 1 || err_k != 7 || err_code_seen !== 2'd3) begin n_bad++; $display("FAIL abort_err: got %0d at k=%0d code %0d want 1 at k=7 code 3", err_cnt, err_k, err_code_seen); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (busy_cnt != 6 || audio_bad != 0) begin n_bad++; $display("FAIL abort_busy_audio: got busy %0d audio bad %0d want 6 0", busy_cnt, audio_bad); end
    audio_en_in = 1'b0; #1;
    n_cmp++; if (audio_en_out !== 1'b0) begin n_bad++; $display("FAIL abort_audio_follow: got %b want 0", audio_en_out); end
    audio_en_in = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); cmd_filter = 6'd1; cmd_count = 9'd2; cmd_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (4) begin @(posedge clk); @(negedge clk); cmd_start = 1'b0; end
    n_cmp++; if (busy !== 1'b1 || coef_wr_msb_data !== 8'hA5 || coef_select !== 6'd1) begin n_bad++; $display("FAIL midload_state: got busy %b msb %h sel %0d want 1 a5 1", busy, coef_wr_msb_data, coef_select); end
    reset = 1'b1; cmd_abort = 1'b1;
    @(negedge clk); reset = 1'b0; cmd_abort = 1'b0; byte_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || byte_ready !== 1'b0 || coef_addr_rst !== 1'b0 || coefficient_wr_en !== 1'b0) begin n_bad++; $display("FAIL midreset_ctrl: got busy %b rdy %b arst %b wr %b want 0 0 0 0", busy, byte_ready, coef_addr_rst, coefficient_wr_en); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL midreset_status: got done %b err %b code %0d want 0 0 0", done, err, err_code); end
    n_cmp++; if (coef_select !== 6'd0 || {coef_wr_msb_data, coef_wr_lsb_data} !== 16'h0000) begin n_bad++; $display("FAIL midreset_regs: got sel %0d data %h want 0 0000", coef_select, {coef_wr_msb_data, coef_wr_lsb_data}); end
    n_cmp++; if (audio_en_out !== 1'b1) begin n_bad++; $display("FAIL midreset_audio: got %b want 1", audio_en_out); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_no_err: got err %b busy %b want 0 0", err, busy); end
  endtask

  initial begin
    test_reset();
    test_valid_load();
    test_bad_cmd();
    test_addr_not_zero();
    test_byte_stall();
    test_abort();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Sequencer that sits between the host register/byte interface and the FIR_Filters coefficient write port. It receives a load command and a stream of coefficient bytes, then drives the FIR's `coef_addr_rst`, `coef_select`, `coef_wr_msb_data`, `coef_wr_lsb_data` and `coefficient_wr_en`. It respects the FIR's one-cycle-registered write enable and auto-incrementing write address. While loading, it gates audio processing off.

## Interface
- `NUM_FILTERS`, default 4: number of coefficient RAMs (valid `coef_select` range 0..NUM_FILTERS-1).
- `MAX_COEFS`, default 511: maximum coefficients per load (9-bit FIR address space).

- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `cmd_start` in 1: one-cycle load request. Sampled only in IDLE.
- `cmd_filter` in 6: target filter index, latched on `cmd_start`.
- `cmd_count` in 9: number of 16-bit coefficients to write, latched on `cmd_start`.
- `cmd_abort` in 1: terminates any load; takes priority over all other inputs.
- `byte_valid` in 1: host byte available.
- `byte_data` in 8: host byte. Order is MSB then LSB per coefficient.
- `byte_ready` out 1: loader accepts `byte_data` on a cycle where `byte_valid && byte_ready`.
- `audio_en_in` in 1: system audio enable.
- `audio_en_out` out 1: `audio_en_in && !busy` (combinational); drives FIR `audio_en`.
- `wr_addr_zero` in 1: from FIR; high when the FIR coefficient write address is 0.
- `coef_addr_rst` out 1: one-cycle FIR write-address reset.
- `coef_select` out 6: target RAM select.
- `coef_wr_msb_data` out 8, `coef_wr_lsb_data` out 8: coefficient halves.
- `coefficient_wr_en` out 1: one-cycle write strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when all coefficients have been written.
- `err` out 1, `err_code` out 2: one-cycle error pulse. `err_code` is held until the next `cmd_start`. Codes: 1 = bad command, 2 = address not zero, 3 = aborted.

## Operation
- FSM states: IDLE, ADDR_RST, ADDR_CHK, GET_MSB, GET_LSB, WRITE, SETTLE.
- IDLE, on `cmd_start`:
  - Reject with `err`, `err_code`=1 and stay in IDLE if `cmd_filter >= NUM_FILTERS`, `cmd_count == 0`, or `cmd_count > MAX_COEFS`.
  - Otherwise latch `coef_select <= cmd_filter`, latch `remaining <= cmd_count`, clear `err_code`, and go to ADDR_RST.
- ADDR_RST: `coef_addr_rst`=1 for exactly one cycle, then go to ADDR_CHK.
- ADDR_CHK (one cycle): if `wr_addr_zero`=0, pulse `err` with code 2 and go to IDLE. Otherwise go to GET_MSB.
- GET_MSB: `byte_ready`=1. On handshake, register the byte into `coef_wr_msb_data` and go to GET_LSB.
- GET_LSB: `byte_ready`=1. On handshake, register the byte into `coef_wr_lsb_data` and go to WRITE.
- WRITE: `coefficient_wr_en`=1 for one cycle and `remaining` decrements. Then go to SETTLE.
- SETTLE (2 cycles, counter-timed): `coef_select` and both data registers are held stable.
  - On exit, if `remaining == 0`, pulse `done` and go to IDLE.
  - Otherwise go to GET_MSB.
- `byte_ready`=0 in every state except GET_MSB and GET_LSB. Bytes offered at other times are not consumed.
- `cmd_start` outside IDLE is ignored.
- `cmd_abort` in any non-IDLE state forces IDLE next cycle and pulses `err` with code 3. `done` is not pulsed.
  - A `coefficient_wr_en` already issued still completes inside the FIR.
  - No further strobes are issued.
  - `cmd_abort` in IDLE has no effect.
- `coef_select` and data registers retain their last value in IDLE. They are not cleared at the end of a load.

## Timing
- Reset values: state IDLE, `busy`=0, `byte_ready`=0, `coef_addr_rst`=0, `coefficient_wr_en`=0, `done`=0, `err`=0, `err_code`=0, `coef_select`=0, both data registers 0, `remaining`=0.
- `audio_en_out` equals `audio_en_in` after reset.
- `cmd_start` at edge N:
  - `busy` and `coef_addr_rst` high during cycle N+1.
  - `wr_addr_zero` is checked during cycle N+2.
  - `byte_ready` high from cycle N+3.
- Per-coefficient minimum is 5 cycles with `byte_valid` held high: MSB, LSB, WRITE, SETTLE, SETTLE.
- FIR write window: select and data must be stable from the `coefficient_wr_en` cycle through the two following cycles, because the FIR registers the enable and the RAM write completes one cycle later. SETTLE guarantees this.
- Consecutive `coefficient_wr_en` pulses are at least 5 cycles apart.
- `done` is asserted in the cycle after the last SETTLE cycle, coincident with `busy`=0.
- `cmd_abort` and `reset` together: reset wins, and no `err` is pulsed.

## Test plan
- Valid load, `cmd_filter`=2, `cmd_count`=3, bytes 12 34 56 78 9A BC with `byte_valid` held high:
  - expect one `coef_addr_rst`;
  - expect 3 `coefficient_wr_en` pulses 5 cycles apart with `{msb,lsb}` = 1234, 5678, 9ABC and `coef_select`=2 throughout;
  - expect `done` 17 cycles after `cmd_start`.
- Bad commands: `cmd_filter`=4, then `cmd_count`=0, then `cmd_count`=512 → each gives one-cycle `err` with `err_code`=1, `busy` stays 0, no strobes.
- `wr_addr_zero` forced to 0 in ADDR_CHK → `err` with code 2, return to IDLE, zero `coefficient_wr_en` pulses.
- Byte stall: `byte_valid` deasserted for 10 cycles between the MSB and LSB of the second coefficient → no strobe until the LSB is accepted, and the written value is still correct.
- `cmd_abort` during the SETTLE of coefficient 1 of 4 → exactly 1 strobe total, `err` code 3, no `done`, `audio_en_out` follows `audio_en_in` next cycle.
- `audio_en_in`=1 throughout a load → `audio_en_out`=0 exactly while `busy`=1. A reset mid-load returns all outputs to their reset values on the next cycle.
